// File: rtl/pe_array_ctrl_pkg.sv
// Shared types and sizing helpers for the pe_array job sequencer.
package pe_array_ctrl_pkg;

  localparam int DEF_AW = 10;
  localparam int DEF_KW = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  // clog2(cycles+1), at least 1, so the drain counter can hold the full count
  function automatic int drain_w(input int cycles);
    int n;
    int w;
    n = cycles + 1;
    w = 1;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) w = i + 1;
    return w;
  endfunction

endpackage

// File: rtl/pe_array_ctrl_if.sv
// Command and done handshake between the layer scheduler and the job sequencer.
interface pe_array_ctrl_if
  import pe_array_ctrl_pkg::*;
#(
  parameter int ARRAY_NUM = 3,
  parameter int AW        = DEF_AW,
  parameter int KW        = DEF_KW
);
  logic                 iCmdValid;
  logic                 oCmdReady;
  logic [KW-1:0]        iCmdTaps;
  logic [AW-1:0]        iCmdWBase;
  logic [AW-1:0]        iCmdDBase;
  logic [ARRAY_NUM-2:0] iCmdPassLeft;
  logic [4:0]           iCmdShift;
  logic                 oDoneValid;
  logic                 iDoneReady;

  modport master (
    output iCmdValid, iCmdTaps, iCmdWBase, iCmdDBase, iCmdPassLeft, iCmdShift, iDoneReady,
    input  oCmdReady, oDoneValid
  );

  modport slave (
    input  iCmdValid, iCmdTaps, iCmdWBase, iCmdDBase, iCmdPassLeft, iCmdShift, iDoneReady,
    output oCmdReady, oDoneValid
  );
endinterface

// File: rtl/pe_array_ctrl_addr_gen.sv
// Buffer address generator: loads a base, then steps by one per enabled read, wrapping at 2^AW.
module pe_addr_gen #(
  parameter int AW = 10
) (
  input  logic          iClk,
  input  logic          iRstN,
  input  logic          iLoad,
  input  logic [AW-1:0] iBase,
  input  logic          iInc,
  output logic [AW-1:0] oAddr
);
  logic [AW-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (iLoad)     addr_d = iBase;
    else if (iInc) addr_d = addr_q + AW'(1);
  end

  always_ff @(posedge iClk or negedge iRstN)
    if (!iRstN) addr_q <= '0;
    else        addr_q <= addr_d;

  assign oAddr = addr_q;
endmodule

// File: rtl/pe_array_ctrl.sv
// Job sequencer for pe_array: clear, stream K taps, drain the array pipeline, hold done.
module pe_array_ctrl
  import pe_array_ctrl_pkg::*;
#(
  parameter int ARRAY_NUM    = 3,
  parameter int AW           = DEF_AW,
  parameter int KW           = DEF_KW,
  parameter int DRAIN_CYCLES = ARRAY_NUM + 2
) (
  input  logic                 iClk,
  input  logic                 iRstN,
  pe_array_ctrl_if.slave       cmd,
  input  logic                 iAbort,
  output logic                 oWeightRdEn,
  output logic [AW-1:0]        oWeightRdAddr,
  input  logic [7:0]           iWeightRdData,
  output logic                 oDataRdEn,
  output logic [AW-1:0]        oDataRdAddr,
  output logic [7:0]           oWeight,
  output logic                 oClearAcc,
  output logic [ARRAY_NUM-2:0] oCfsPassDataLeft,
  output logic [4:0]           oCfsOutputLeftShift,
  output logic                 oBusy
);
  localparam int DW = drain_w(DRAIN_CYCLES);

  state_e               state_q, state_d;
  logic [KW-1:0]        taps_q, taps_d, cnt_q, cnt_d;
  logic [DW-1:0]        dcnt_q, dcnt_d;
  logic [ARRAY_NUM-2:0] pass_q, pass_d;
  logic [4:0]           shift_q, shift_d;
  logic                 rd_en_q, rd_en_d, clr_q, clr_d, done_q, done_d;
  logic                 rdy_q, rdy_d, busy_q, busy_d, rd_vld_q, rd_vld_d;
  logic                 accept;

  assign accept = cmd.iCmdValid & rdy_q;

  always_comb begin
    state_d = state_q;
    taps_d  = taps_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    pass_d  = pass_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d = S_CLEAR;
        taps_d  = cmd.iCmdTaps;
        pass_d  = cmd.iCmdPassLeft;
        shift_d = cmd.iCmdShift;
      end
      // K=0 skips the stream; one cycle less of drain lines done up with the K>0 timing
      S_CLEAR: begin
        cnt_d = '0;
        if (taps_q != '0) state_d = S_STREAM;
        else begin
          state_d = S_DRAIN;
          dcnt_d  = DW'(DRAIN_CYCLES - 1);
        end
      end
      S_STREAM: begin
        cnt_d = cnt_q + KW'(1);
        if (cnt_q == taps_q - KW'(1)) begin
          state_d = S_DRAIN;
          dcnt_d  = DW'(DRAIN_CYCLES);
        end
      end
      S_DRAIN: if (dcnt_q == '0) state_d = S_DONE;
               else              dcnt_d  = dcnt_q - DW'(1);
      S_DONE:  if (cmd.iDoneReady) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (iAbort && state_q != S_IDLE) state_d = S_IDLE;
  end

  // outputs are registered decodes of the next state
  assign rd_en_d  = (state_d == S_STREAM);
  assign clr_d    = (state_d == S_CLEAR);
  assign done_d   = (state_d == S_DONE);
  assign rdy_d    = (state_d == S_IDLE);
  assign busy_d   = (state_d != S_IDLE);
  assign rd_vld_d = rd_en_q;

  always_ff @(posedge iClk or negedge iRstN)
    if (!iRstN) begin
      state_q  <= S_IDLE;
      taps_q   <= '0;
      cnt_q    <= '0;
      dcnt_q   <= '0;
      pass_q   <= '0;
      shift_q  <= '0;
      rd_en_q  <= 1'b0;
      clr_q    <= 1'b0;
      done_q   <= 1'b0;
      rdy_q    <= 1'b1;
      busy_q   <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      taps_q   <= taps_d;
      cnt_q    <= cnt_d;
      dcnt_q   <= dcnt_d;
      pass_q   <= pass_d;
      shift_q  <= shift_d;
      rd_en_q  <= rd_en_d;
      clr_q    <= clr_d;
      done_q   <= done_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
      rd_vld_q <= rd_vld_d;
    end

  pe_addr_gen #(.AW(AW)) u_waddr (
    .iClk(iClk), .iRstN(iRstN), .iLoad(accept), .iBase(cmd.iCmdWBase),
    .iInc(rd_en_q), .oAddr(oWeightRdAddr)
  );

  pe_addr_gen #(.AW(AW)) u_daddr (
    .iClk(iClk), .iRstN(iRstN), .iLoad(accept), .iBase(cmd.iCmdDBase),
    .iInc(rd_en_q), .oAddr(oDataRdAddr)
  );

  // unqualified read data is forced to zero so frozen accumulators add nothing
  assign oWeight             = rd_vld_q ? iWeightRdData : 8'd0;
  assign oWeightRdEn         = rd_en_q;
  assign oDataRdEn           = rd_en_q;
  assign oClearAcc           = clr_q;
  assign oCfsPassDataLeft    = pass_q;
  assign oCfsOutputLeftShift = shift_q;
  assign oBusy               = busy_q;
  assign cmd.oCmdReady       = rdy_q;
  assign cmd.oDoneValid      = done_q;
endmodule

// File: doc/pe_array_ctrl.md
Name: pe_array_ctrl

Overview:
Sequences one pe_array job: accepts a command, pulses the accumulator clear, and streams K weight taps from the weight buffer. In parallel it issues the matching data-buffer reads, waits for the array pipeline to drain, then holds a done handshake while the accumulators are frozen. It sits between the layer scheduler (command side) and the pe_array/weight/data SRAMs (datapath side). It also drives the array's static configuration: pass-left mask and output shift.

Parameters:
ARRAY_NUM, 3, PE count; sets pass-left mask width ARRAY_NUM-1.
AW, 10, weight/data buffer address width.
KW, 8, tap-count width; maximum K = 2^KW-1.
DRAIN_CYCLES, ARRAY_NUM+2, cycles between last weight read-data and done.

Ports:
iClk  in  1  clock.
iRstN  in  1  reset; one clock; reset is asynchronous and active-low.
iCmdValid  in  1  command valid.
oCmdReady  out  1  high only in IDLE.
iCmdTaps  in  KW  tap count K.
iCmdWBase  in  AW  weight base address.
iCmdDBase  in  AW  data base address.
iCmdPassLeft  in  ARRAY_NUM-1  pass-left mask for the job.
iCmdShift  in  5  output shift for the job.
iAbort  in  1  synchronous abort.
oWeightRdEn  out  1  weight buffer read enable.
oWeightRdAddr  out  AW  weight read address.
iWeightRdData  in  8  weight read data, 1-cycle latency.
oDataRdEn  out  1  data buffer read enable.
oDataRdAddr  out  AW  data read address.
oWeight  out  8  weight to array.
oClearAcc  out  1  accumulator clear.
oCfsPassDataLeft  out  ARRAY_NUM-1  latched pass-left mask.
oCfsOutputLeftShift  out  5  latched shift.
oBusy  out  1  state != IDLE.
oDoneValid  out  1  result stable at array output.
iDoneReady  in  1  consumer took the result.

Behaviour:
- Reset (async assert, sync deassert by the environment): state IDLE. All outputs 0 except oCmdReady=1. Counters and latched config are 0.
- States: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE: oCmdReady=1. On iCmdValid&oCmdReady (cycle T), latch taps, bases, mask and shift, then go to CLEAR.
- CLEAR (T+1): oClearAcc=1 for exactly one cycle. Go to STREAM if K>0, otherwise DRAIN.
- STREAM (T+2 .. T+1+K):
  - oWeightRdEn=oDataRdEn=1.
  - Addresses are WBase+k and DBase+k for k=0..K-1, modulo 2^AW (wrap, no error).
  - Exit to DRAIN after the K-th read.
- Weight mux: a registered copy of oWeightRdEn qualifies the read data. oWeight = iWeightRdData when qualified, else 8'd0. Valid weights therefore appear at T+3..T+2+K.
- Zero-weight guarantee: in every non-STREAM cycle, oWeight is 0 after the final read-data cycle. Accumulators therefore hold, since acc += 0.
- DRAIN: count DRAIN_CYCLES cycles, starting the cycle after the last qualified weight (or after CLEAR when K=0), then go to DONE.
- DONE: oDoneValid=1 until iDoneReady is sampled high, then IDLE. A new command may be accepted only in the cycle after that return (no same-cycle bypass).
- oCfsPassDataLeft and oCfsOutputLeftShift hold the last latched job values through IDLE, so the array output stays consistent until the next accept. The shift passes through unmodified (0..31).
- iAbort: in any non-IDLE state, the next state is IDLE, with rd enables, oClearAcc and oDoneValid low the next cycle. No done is produced. The in-flight read data is still qualified once (harmless).
- iAbort in IDLE: ignored, and a same-cycle command is still accepted.
- iAbort together with iDoneReady in DONE: result is IDLE either way.
- iCmdValid outside IDLE: ignored and not queued.
- Reset mid-job: immediate return to reset values, no done.

Decomposition:
- Package pe_array_ctrl_pkg:
  - state enum (3-bit encoding IDLE=0, CLEAR=1, STREAM=2, DRAIN=3, DONE=4);
  - default AW/KW;
  - drain-counter width function clog2(DRAIN_CYCLES+1).
- One natural sub-module, pe_addr_gen: base latch plus incrementing AW-bit address with wrap and enable. Instantiated twice (weight and data).

Test Plan:
- Reset then cmd K=4, WBase=0x10, DBase=0x20, shift=3, mask=2'b01 → oClearAcc high at T+1; weight addrs 0x10..0x13 at T+2..T+5; oWeight nonzero only at T+3..T+6; oDoneValid rises at T+6+DRAIN_CYCLES+1; mask/shift outputs 2'b01/3.
- Cmd K=0 → CLEAR, then DRAIN (DRAIN_CYCLES cycles), then DONE; no rd enables ever asserted.
- WBase=0x3FE, K=4, AW=10 → addresses 0x3FE, 0x3FF, 0x000, 0x001.
- Hold iDoneReady low 10 cycles → oDoneValid stays high, oWeight=0, oCmdReady=0; a second iCmdValid is ignored. Assert ready → IDLE next cycle, and the pending cmd is accepted the cycle after.
- iAbort during STREAM at k=2 → rd enables low next cycle, state IDLE, no oDoneValid; the following cmd runs normally.
- Assert iRstN low mid-DRAIN, asynchronously → outputs reset immediately without a clock edge; oCmdReady=1 after release.
